// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings, default register-index width and the forward priority helper
package hazard_pkg;
    localparam int DEF_REG_AW = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        return hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/md_tracker.sv
// md_tracker: tracks one in-flight multi-cycle op (busy flag, latency down-counter, latched destination)
//   in : clk, rst (sync, active-high), issue, issue_rd
//   out: busy, done (last busy cycle), rd (latched destination)
module md_tracker import hazard_pkg::*; #(
    parameter int REG_AW = DEF_REG_AW,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rd
);
    localparam int CW = $clog2(MD_LAT);
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              last;
    // An issue seen while busy is a protocol violation and is dropped.
    always_comb begin
        last   = cnt_q == '0;
        busy_d = busy_q ? !last : issue;
        cnt_d  = busy_q ? (last ? cnt_q : cnt_q - CW'(1)) : (issue ? CW'(MD_LAT - 1) : cnt_q);
        rd_d   = (!busy_q && issue) ? issue_rd : rd_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rd_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
        end
    end
    assign busy = busy_q;
    assign done = busy_q && last && !rst;
    assign rd   = rd_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit -- operand forwarding, load-use and multi-cycle stalls, branch flushes, stall counter
//   in : clk, rst (sync, active-high), Rs1_D/Rs2_D, Rs1_E/Rs2_E/RD_E, LoadE, PCSrcE,
//        RegWriteM/RD_M, RegWriteW/RD_W, MdIssueE/MdRdE
//   out: ForwardAE/ForwardBE, StallF/StallD/FlushD/FlushE, MdBusy/MdDone, StallCnt
//   macro HAZARD_MD_EN: enables the multi-cycle op tracker and its stall; otherwise MdIssueE/MdRdE are ignored
module hazard_ctrl import hazard_pkg::*; #(
    parameter int REG_AW = DEF_REG_AW,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RD_M,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              MdIssueE,
    input  logic [REG_AW-1:0] MdRdE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdDone,
    output logic [CNT_W-1:0]  StallCnt
);
    logic             md_busy, md_done, md_stall, lw_stall, stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`ifdef HAZARD_MD_EN
    logic [REG_AW-1:0] md_rd;
    md_tracker #(.REG_AW(REG_AW), .MD_LAT(MD_LAT)) u_md (
        .clk      (clk),
        .rst      (rst),
        .issue    (MdIssueE),
        .issue_rd (MdRdE),
        .busy     (md_busy),
        .done     (md_done),
        .rd       (md_rd)
    );
    assign md_stall = md_busy && md_rd != '0 && (md_rd == Rs1_D || md_rd == Rs2_D);
`else
    logic unused_md;
    assign unused_md = ^{MdIssueE, MdRdE};
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign md_stall  = 1'b0;
`endif
    // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
    always_comb begin
        lw_stall    = LoadE && RD_E != '0 && (RD_E == Rs1_D || RD_E == Rs2_D);
        stall       = !rst && !PCSrcE && (lw_stall || md_stall);
        ForwardAE   = rst ? FWD_RF : fwd_sel(RegWriteM && RD_M != '0 && RD_M == Rs1_E,
                                             RegWriteW && RD_W != '0 && RD_W == Rs1_E);
        ForwardBE   = rst ? FWD_RF : fwd_sel(RegWriteM && RD_M != '0 && RD_M == Rs2_E,
                                             RegWriteW && RD_W != '0 && RD_W == Rs2_E);
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign StallF   = stall;
    assign StallD   = stall;
    assign FlushD   = !rst && PCSrcE;
    assign FlushE   = (!rst && PCSrcE) || stall;
    assign MdBusy   = md_busy;
    assign MdDone   = md_done;
    assign StallCnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven, directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 8;
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic          load_e, pcsrc_e, we_m;
        logic [AW-1:0] rd_m;
        logic          we_w;
        logic [AW-1:0] rd_w;
        logic          md_issue;
        logic [AW-1:0] md_rd;
    } in_t;

    typedef struct {
        in_t        i;
        logic [1:0] fa, fb;
        logic       stall, flush_d, flush_e;
    } vec_t;

    logic clk = 1'b0;
    in_t  vi;
    logic [1:0]    fa, fb;
    logic          stall_f, stall_d, flush_d, flush_e, md_busy, md_done;
    logic [CW-1:0] stall_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    int            m_rem = 0;
    logic [AW-1:0] m_rd  = '0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .MD_LAT(LAT), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (vi.rst),
        .Rs1_D     (vi.rs1_d),
        .Rs2_D     (vi.rs2_d),
        .Rs1_E     (vi.rs1_e),
        .Rs2_E     (vi.rs2_e),
        .RD_E      (vi.rd_e),
        .LoadE     (vi.load_e),
        .PCSrcE    (vi.pcsrc_e),
        .RegWriteM (vi.we_m),
        .RD_M      (vi.rd_m),
        .RegWriteW (vi.we_w),
        .RD_W      (vi.rd_w),
        .MdIssueE  (vi.md_issue),
        .MdRdE     (vi.md_rd),
        .ForwardAE (fa),
        .ForwardBE (fb),
        .StallF    (stall_f),
        .StallD    (stall_d),
        .FlushD    (flush_d),
        .FlushE    (flush_e),
        .MdBusy    (md_busy),
        .MdDone    (md_done),
        .StallCnt  (stall_cnt)
    );

    function automatic in_t idle();
        in_t r = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: forward source is the youngest in-flight writer; an op in flight
    // occupies the unit for LAT cycles, counted as cycles remaining.
    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
        if (vi.rst) return 2'd0;
        if (vi.we_m && vi.rd_m != 0 && vi.rd_m == rs) return 2'd2;
        if (vi.we_w && vi.rd_w != 0 && vi.rd_w == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        logic lw, md;
        lw = vi.load_e && vi.rd_e != 0 && (vi.rd_e == vi.rs1_d || vi.rd_e == vi.rs2_d);
        md = m_rem > 0 && m_rd != 0 && (m_rd == vi.rs1_d || m_rd == vi.rs2_d);
        return !vi.rst && !vi.pcsrc_e && (lw || md);
    endfunction

    task automatic sample();
        logic s;
        @(negedge clk);
        s = m_stall();
        chk("m_fwd_a",   fa,        m_fwd(vi.rs1_e));
        chk("m_fwd_b",   fb,        m_fwd(vi.rs2_e));
        chk("m_stall_f", stall_f,   s);
        chk("m_stall_d", stall_d,   s);
        chk("m_flush_d", flush_d,   !vi.rst && vi.pcsrc_e);
        chk("m_flush_e", flush_e,   (!vi.rst && vi.pcsrc_e) || s);
        chk("m_md_busy", md_busy,   m_rem > 0);
        chk("m_md_done", md_done,   !vi.rst && m_rem == 1);
        chk("m_cnt",     stall_cnt, m_cnt);
    endtask

    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (vi.rst) begin
            m_rem = 0;
            m_rd  = '0;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_rem > 0) m_rem--;
            else if (MD_EN && vi.md_issue) begin
                m_rem = LAT;
                m_rd  = vi.md_rd;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        vi = idle();
        vi.rst = 1'b1;
        vi.we_m = 1'b1; vi.rd_m = 5'd2; vi.rs1_e = 5'd2;
        vi.load_e = 1'b1; vi.rd_e = 5'd2; vi.rs1_d = 5'd2; vi.pcsrc_e = 1'b1;
        tick();
        sample();
        chk("rst_fwd_a", fa, 2'b00);
        chk("rst_stall", stall_d, 1'b0);
        chk("rst_flush", {flush_d, flush_e}, 2'b00);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_busy", md_busy, 1'b0);
        tick();
        vi = idle();
    endtask

    vec_t tbl[7];

    initial begin
        in_t t;
        int  exp_sc;
        t = idle(); t.we_m = 1; t.rd_m = 3; t.we_w = 1; t.rd_w = 3; t.rs1_e = 3;
        tbl[0] = '{t, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        t.rd_m = 0;
        tbl[1] = '{t, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        t = idle(); t.load_e = 1; t.rd_e = 7; t.rs2_d = 7;
        tbl[2] = '{t, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
        t.rd_e = 0; t.rs2_d = 0;
        tbl[3] = '{t, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        t = idle(); t.load_e = 1; t.rd_e = 7; t.rs1_d = 7; t.pcsrc_e = 1;
        tbl[4] = '{t, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        t = idle(); t.we_m = 0; t.rd_m = 9; t.we_w = 1; t.rd_w = 9; t.rs2_e = 9;
        tbl[5] = '{t, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
        t = idle(); t.we_m = 1; t.rd_m = 4; t.we_w = 1; t.rd_w = 6; t.rs1_e = 4; t.rs2_e = 4;
        tbl[6] = '{t, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};

        do_reset();
        exp_sc = 0;
        foreach (tbl[k]) begin
            vi = tbl[k].i;
            sample();
            chk($sformatf("tbl%0d_fa", k), fa, tbl[k].fa);
            chk($sformatf("tbl%0d_fb", k), fb, tbl[k].fb);
            chk($sformatf("tbl%0d_stall", k), {stall_f, stall_d}, {2{tbl[k].stall}});
            chk($sformatf("tbl%0d_flush_d", k), flush_d, tbl[k].flush_d);
            chk($sformatf("tbl%0d_flush_e", k), flush_e, tbl[k].flush_e);
            exp_sc += int'(tbl[k].stall);
            tick();
            chk($sformatf("tbl%0d_cnt", k), stall_cnt, exp_sc);
        end

`ifdef HAZARD_MD_EN
        // Single op: issue at edge 0, destination read in decode throughout.
        do_reset();
        vi.md_issue = 1; vi.md_rd = 5; vi.rs1_d = 5;
        sample();
        chk("md_c0_busy", md_busy, 1'b0);
        tick();
        vi.md_issue = 0;
        for (int c = 1; c <= 5; c++) begin
            sample();
            chk($sformatf("md_c%0d_busy", c), md_busy, c <= 4);
            chk($sformatf("md_c%0d_stall", c), stall_d, c <= 4);
            chk($sformatf("md_c%0d_done", c), md_done, c == 4);
            tick();
        end

        // Second issue while busy is dropped.
        do_reset();
        vi.md_issue = 1; vi.md_rd = 5;
        tick();
        vi = idle();
        tick();
        vi.md_issue = 1; vi.md_rd = 9;
        tick();
        vi = idle(); vi.rs1_d = 9;
        sample();
        chk("dup_c3_stall_rd9", stall_d, 1'b0);
        chk("dup_c3_done", md_done, 1'b0);
        tick();
        vi.rs1_d = 5;
        sample();
        chk("dup_c4_stall_rd5", stall_d, 1'b1);
        chk("dup_c4_done", md_done, 1'b1);
        tick();
        vi = idle();
        sample();
        chk("dup_c5_busy", md_busy, 1'b0);
        tick();

        // Reset in cycle 3 aborts the op.
        do_reset();
        vi.md_issue = 1; vi.md_rd = 5;
        tick();
        vi = idle();
        tick();
        tick();
        vi.rst = 1;
        sample();
        chk("abort_c3_done", md_done, 1'b0);
        tick();
        vi.rst = 0;
        for (int c = 4; c <= 7; c++) begin
            sample();
            chk($sformatf("abort_c%0d_busy", c), md_busy, 1'b0);
            chk($sformatf("abort_c%0d_done", c), md_done, 1'b0);
            tick();
        end

        // Branch does not cancel an op in flight.
        do_reset();
        vi.md_issue = 1; vi.md_rd = 3;
        tick();
        vi = idle(); vi.pcsrc_e = 1; vi.rs2_d = 3;
        for (int c = 1; c <= 4; c++) begin
            sample();
            chk($sformatf("br_c%0d_busy", c), md_busy, 1'b1);
            chk($sformatf("br_c%0d_stall", c), stall_d, 1'b0);
            tick();
        end
`else
        do_reset();
        vi.md_issue = 1; vi.md_rd = 5; vi.rs1_d = 5;
        for (int c = 0; c <= 5; c++) begin
            sample();
            chk($sformatf("nomd_c%0d_busy", c), md_busy, 1'b0);
            chk($sformatf("nomd_c%0d_stall", c), stall_d, 1'b0);
            tick();
        end
`endif

        // Saturation of the stall counter.
        do_reset();
        vi.load_e = 1; vi.rd_e = 7; vi.rs1_d = 7;
        for (int c = 0; c < (1 << CW) + 5; c++) begin
            if (c % 16 == 0) sample();
            tick();
        end
        chk("sat_cnt", stall_cnt, (1 << CW) - 1);
        sample();
        tick();
        chk("sat_hold", stall_cnt, (1 << CW) - 1);

        // Randomized traffic over a small register range so collisions are frequent.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            vi.rst      = $urandom_range(0, 60) == 0;
            vi.rs1_d    = AW'($urandom_range(0, 3));
            vi.rs2_d    = AW'($urandom_range(0, 3));
            vi.rs1_e    = AW'($urandom_range(0, 3));
            vi.rs2_e    = AW'($urandom_range(0, 3));
            vi.rd_e     = AW'($urandom_range(0, 3));
            vi.load_e   = $urandom_range(0, 2) == 0;
            vi.pcsrc_e  = $urandom_range(0, 5) == 0;
            vi.we_m     = 1'($urandom_range(0, 1));
            vi.rd_m     = AW'($urandom_range(0, 3));
            vi.we_w     = 1'($urandom_range(0, 1));
            vi.rd_w     = AW'($urandom_range(0, 3));
            vi.md_issue = $urandom_range(0, 6) == 0;
            vi.md_rd    = AW'($urandom_range(0, 3));
            sample();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
